// File: rtl/helios_stream_fifo.sv
// helios_stream_fifo
//   First-word-fall-through FIFO with valid/ready handshakes on both sides.
//   Decouples the host byte stream from the Helios decoder (and back).
//
// Parameters
//   WIDTH   data word width in bits
//   DEPTH   number of entries; power of two, at least 2
//   ADDR_W  derived pointer width, leave at default
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   input_data    write-side data
//   input_valid   write-side valid
//   input_ready   write-side ready, high while not full
//   output_data   head-of-queue data, zero while empty
//   output_valid  read-side valid, high while not empty
//   output_ready  read-side ready from consumer
//   fill_level    number of stored words, 0..DEPTH
//   high_water    (only with FIFO_HIGH_WATER_EN) max fill level since reset
//
// Build option
//   FIFO_HIGH_WATER_EN  adds the high_water port and its register.

module helios_stream_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  input_data,
  input  logic              input_valid,
  output logic              input_ready,
  output logic [WIDTH-1:0]  output_data,
  output logic              output_valid,
  input  logic              output_ready,
`ifdef FIFO_HIGH_WATER_EN
  output logic [ADDR_W:0]   high_water,
`endif
  output logic [ADDR_W:0]   fill_level
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              pop;

  // Flags derive from the registered count only; no input-to-output bypass.
  assign input_ready  = (count != CNT_W'(DEPTH));
  assign output_valid = (count != '0);
  assign fill_level   = count;
  assign output_data  = output_valid ? mem[rd_ptr] : '0;

  assign push = input_valid  && input_ready;
  assign pop  = output_valid && output_ready;

  // Occupancy update: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_next;
    end
  end

  // Storage is not reset; input_data is only sampled on a real push.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= input_data;
  end

`ifdef FIFO_HIGH_WATER_EN
  // Peak occupancy; bounded by DEPTH since count never exceeds it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_water <= '0;
    end else if (count_next > high_water) begin
      high_water <= count_next;
    end
  end
`endif

endmodule

// File: tb/tb_helios_stream_fifo.sv
module tb_helios_stream_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] input_data = '0;
  logic             input_valid = 1'b0;
  logic             input_ready;
  logic [WIDTH-1:0] output_data;
  logic             output_valid;
  logic             output_ready = 1'b0;
  logic [AW:0]      fill_level;
`ifdef FIFO_HIGH_WATER_EN
  logic [AW:0]      high_water;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  // Reference model: a plain queue of accepted words plus a peak counter.
  logic [WIDTH-1:0] exp_q[$];
  int               hw_model = 0;
  bit               m_push;
  bit               m_pop;
  logic [WIDTH-1:0] m_word;

  helios_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
`ifdef FIFO_HIGH_WATER_EN
    .high_water   (high_water),
`endif
    .fill_level   (fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard update: a word is accepted if the model has room, and the head
  // leaves when the model is non-empty and the consumer is ready.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      hw_model = 0;
    end else begin
      m_pop  = (exp_q.size() != 0) && output_ready;
      m_push = input_valid && (exp_q.size() != DEPTH);
      m_word = input_data;
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(m_word);
      if (exp_q.size() > hw_model) hw_model = exp_q.size();
    end
  end

  // Monitor: on the falling edge compare what the DUT presents with the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("output_valid", 32'(output_valid), 32'(exp_q.size() != 0));
      chk("input_ready",  32'(input_ready),  32'(exp_q.size() != DEPTH));
      chk("fill_level",   32'(fill_level),   32'(exp_q.size()));
      chk("output_data",  32'(output_data),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
`ifdef FIFO_HIGH_WATER_EN
      chk("high_water",   32'(high_water),   32'(hw_model));
`endif
    end
  end

  // Present inputs for one clock, return just after the edge.
  task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit r);
    input_valid  = v;
    input_data   = d;
    output_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && output_valid; i++) cyc(1'b0, 8'($urandom), 1'b1);
    chk("drain_empty", 32'(output_valid), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(input_ready),  32'd1);
    chk("rst_valid", 32'(output_valid), 32'd0);
    chk("rst_data",  32'(output_data),  32'd0);
    chk("rst_fill",  32'(fill_level),   32'd0);
    reset = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);

    // Single word through an empty FIFO.
    cyc(1'b1, 8'hA5, 1'b0);
    chk("single_valid", 32'(output_valid), 32'd1);
    chk("single_data",  32'(output_data),  32'hA5);
    chk("single_fill",  32'(fill_level),   32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("single_popped", 32'(output_valid), 32'd0);
    chk("single_fill0",  32'(fill_level),   32'd0);

    // Fill to full; the extra 0xFF must be refused.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("full_ready", 32'(input_ready), 32'd0);
    chk("full_fill",  32'(fill_level),  32'd128);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("full_noover", 32'(fill_level), 32'd128);
`ifdef FIFO_HIGH_WATER_EN
    chk("hw_full", 32'(high_water), 32'd128);
`endif

    // Pop one while full, then refill.
    cyc(1'b0, 8'h00, 1'b1);
    chk("free_ready", 32'(input_ready), 32'd1);
    chk("free_fill",  32'(fill_level),  32'd127);
    cyc(1'b1, 8'h80, 1'b0);
    chk("refull_fill", 32'(fill_level), 32'd128);
    drain();

    // Steady push+pop at half occupancy across several pointer wraps.
    for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 8'(64 + i), 1'b1);
    chk("stream_fill", 32'(fill_level), 32'd64);
    drain();

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i + 8'h10), 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(output_valid), 32'd0);
    chk("midrst_fill",  32'(fill_level),   32'd0);
    chk("midrst_data",  32'(output_data),  32'd0);
`ifdef FIFO_HIGH_WATER_EN
    chk("midrst_hw", 32'(high_water), 32'd0);
`endif
    input_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(1'b1, 8'h3C, 1'b0);
    chk("after_rst_head", 32'(output_data), 32'h3C);
    drain();

    // Random traffic with varying pressure on each side.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 400; i++) begin
        bit v, r;
        v = ($urandom_range(0, 9) < ((p == 1) ? 9 : (p == 2) ? 2 : 5));
        r = ($urandom_range(0, 9) < ((p == 1) ? 2 : (p == 2) ? 9 : 5));
        cyc(v, 8'($urandom), r);
      end
    end
    drain();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
